// File: rtl/cipher_sched_pkg.sv
// Shared types and constants for the cipher block scheduler.
package cipher_sched_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_FILL = 2'd1,
    ST_LAST = 2'd2,
    ST_OUT  = 2'd3
  } state_t;

  localparam int BYTES_PER_BLOCK = 8;
  localparam int POP_CNT_W       = 4;
  localparam int BYTE_IDX_W      = 3;

  typedef logic src_id_t;

  // Round-robin pick: contention goes to the source not granted last.
  function automatic src_id_t rr_pick(input logic req0, input logic req1, input src_id_t last_src);
    src_id_t pick;
    if (req0 && req1) begin
      pick = ~last_src;
    end else if (req0) begin
      pick = 1'b0;
    end else begin
      pick = 1'b1;
    end
    return pick;
  endfunction

endpackage

// File: rtl/cipher_sched_byte_packer.sv
// byte_packer: assembles bytes, first byte in the least significant lane, into one cipher block.
module byte_packer
  import cipher_sched_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        clr,
  input  logic        cap,
  input  logic [7:0]  din,
  output logic [63:0] dout
);

  logic [63:0]           data_r;
  logic [BYTE_IDX_W-1:0] idx_r;

  // Byte lane write; clr only rewinds the lane index so an offered block stays intact.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      data_r <= 64'd0;
      idx_r  <= '0;
    end else if (clr) begin
      idx_r  <= '0;
    end else if (cap) begin
      data_r[{idx_r, 3'b000} +: 8] <= din;
      idx_r                        <= idx_r + 3'd1;
    end
  end

  assign dout = data_r;

endmodule

// File: rtl/cipher_sched.sv
// cipher_sched: round-robin scheduler packing 8-byte blocks from two byte FIFOs for a cipher core.
// Optional per-source accepted-block counters are enabled with `define CIPHER_SCHED_STATS_EN.
module cipher_sched #(
  parameter int BYTES_PER_BLOCK = 8,
  parameter int FIFO_RD_LAT     = 1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        fifo0_empty,
  output logic        fifo0_rd_en,
  input  logic [7:0]  fifo0_data,
  input  logic        fifo1_empty,
  output logic        fifo1_rd_en,
  input  logic [7:0]  fifo1_data,
  output logic [63:0] blk_data,
  output logic        blk_src,
  output logic        blk_valid,
  input  logic        blk_ready,
  output logic        busy
`ifdef CIPHER_SCHED_STATS_EN
  ,
  output logic [15:0] blk_cnt0,
  output logic [15:0] blk_cnt1
`endif
);
  import cipher_sched_pkg::*;

  if (BYTES_PER_BLOCK != 8) begin : g_bad_bytes
    $error("cipher_sched: BYTES_PER_BLOCK must be 8");
  end
  if (FIFO_RD_LAT != 1) begin : g_bad_lat
    $error("cipher_sched: FIFO_RD_LAT must be 1");
  end

  localparam logic [POP_CNT_W-1:0] LAST_POP = POP_CNT_W'(BYTES_PER_BLOCK - 1);

  state_t                 state_r, state_nxt_s;
  src_id_t                grant_r, grant_nxt_s;
  src_id_t                last_r, last_nxt_s;
  logic [POP_CNT_W-1:0]   pop_cnt_r;
  logic                   pop_d_r;
  logic                   blk_valid_r;
  logic                   busy_r;
  logic                   pop_s;
  logic                   rd0_s;
  logic                   rd1_s;
  logic                   accept_s;
  logic                   clr_s;
  logic [7:0]             din_s;

  // Next-state, arbitration and pop decode.
  always_comb begin
    state_nxt_s = state_r;
    grant_nxt_s = grant_r;
    last_nxt_s  = last_r;
    pop_s       = 1'b0;
    accept_s    = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (!fifo0_empty || !fifo1_empty) begin
          grant_nxt_s = rr_pick(!fifo0_empty, !fifo1_empty, last_r);
          state_nxt_s = ST_FILL;
        end else begin
          state_nxt_s = ST_IDLE;
        end
      end
      ST_FILL: begin
        pop_s = (pop_cnt_r <= LAST_POP) && (grant_r ? !fifo1_empty : !fifo0_empty);
        if (pop_s && (pop_cnt_r == LAST_POP)) begin
          state_nxt_s = ST_LAST;
        end else begin
          state_nxt_s = ST_FILL;
        end
      end
      ST_LAST: begin
        state_nxt_s = ST_OUT;
      end
      ST_OUT: begin
        if (blk_ready) begin
          accept_s    = 1'b1;
          last_nxt_s  = grant_r;
          state_nxt_s = ST_IDLE;
        end else begin
          state_nxt_s = ST_OUT;
        end
      end
      default: begin
        state_nxt_s = ST_IDLE;
      end
    endcase
  end

  assign rd0_s = pop_s && (grant_r == 1'b0);
  assign rd1_s = pop_s && (grant_r == 1'b1);

  // FSM, grant lock, pop counter and registered status outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r     <= ST_IDLE;
      grant_r     <= 1'b0;
      last_r      <= 1'b1;
      pop_cnt_r   <= '0;
      pop_d_r     <= 1'b0;
      blk_valid_r <= 1'b0;
      busy_r      <= 1'b0;
    end else begin
      state_r     <= state_nxt_s;
      grant_r     <= grant_nxt_s;
      last_r      <= last_nxt_s;
      pop_d_r     <= pop_s;
      blk_valid_r <= (state_nxt_s == ST_OUT);
      busy_r      <= (state_nxt_s != ST_IDLE);
      if (state_r == ST_IDLE) begin
        pop_cnt_r <= '0;
      end else if (pop_s) begin
        pop_cnt_r <= pop_cnt_r + 4'd1;
      end
    end
  end

  // Read data arrives one cycle after the pop, so capture is driven by the delayed pop.
  assign clr_s = (state_r == ST_IDLE);
  assign din_s = grant_r ? fifo1_data : fifo0_data;

  byte_packer u_packer (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (clr_s),
    .cap   (pop_d_r),
    .din   (din_s),
    .dout  (blk_data)
  );

  assign fifo0_rd_en = rd0_s;
  assign fifo1_rd_en = rd1_s;
  assign blk_src     = grant_r;
  assign blk_valid   = blk_valid_r;
  assign busy        = busy_r;

`ifdef CIPHER_SCHED_STATS_EN
  logic [15:0] cnt0_r;
  logic [15:0] cnt1_r;

  // Accepted-block counters per source, free-running wrap.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt0_r <= 16'd0;
      cnt1_r <= 16'd0;
    end else if (accept_s) begin
      if (grant_r) begin
        cnt1_r <= cnt1_r + 16'd1;
      end else begin
        cnt0_r <= cnt0_r + 16'd1;
      end
    end
  end

  assign blk_cnt0 = cnt0_r;
  assign blk_cnt1 = cnt1_r;
`endif

endmodule

// File: doc/cipher_sched.md
CIPHER_SCHED -- requirements
Module: cipher_sched

Interface
REQ-001 The block SHALL have these parameters (name, default, meaning):
- BYTES_PER_BLOCK, 8, bytes packed per cipher block; the only legal value is 8.
- FIFO_RD_LAT, 1, cycles from fifoN_rd_en to valid fifoN_data; the only legal value is 1.

REQ-002 The block SHALL have these ports (name, direction, width, meaning):
- clk, in, 1: single clock, all logic on rising edge.
- rst_n, in, 1: asynchronous active-low reset.
- fifo0_empty, in, 1: source 0 (video) byte FIFO empty.
- fifo0_rd_en, out, 1: source 0 FIFO pop.
- fifo0_data, in, 8: source 0 FIFO read data.
- fifo1_empty, in, 1: source 1 (audio) byte FIFO empty.
- fifo1_rd_en, out, 1: source 1 FIFO pop.
- fifo1_data, in, 8: source 1 FIFO read data.
- blk_data, out, 64: packed block to the cipher core.
- blk_src, out, 1: source ID of blk_data.
- blk_valid, out, 1: block offer to the cipher core.
- blk_ready, in, 1: cipher core accepts the block.
- busy, out, 1: high in any state other than IDLE.

Function
REQ-003 The FSM SHALL have four states: IDLE, FILL, LAST, OUT.
REQ-004 In IDLE, if either FIFO is non-empty, the block SHALL grant one source and enter FILL on the next edge; otherwise it SHALL stay in IDLE.
REQ-005 Arbitration SHALL be round-robin: with both FIFOs non-empty, the source not granted last wins; with one non-empty, that source wins.
REQ-006 The grant SHALL stay locked until the block is accepted; bytes from the two sources SHALL never interleave within a block.
REQ-007 In FILL, the granted fifoN_rd_en SHALL equal !fifoN_empty while fewer than 8 pops have been issued. The non-granted rd_en SHALL stay 0.
REQ-008 Data SHALL be captured one cycle after each pop. Byte k (k=0 first) SHALL land in blk_data[8k+7:8k].
REQ-009 After the 8th pop, FILL SHALL go to LAST (capture of the final byte, no pop). LAST SHALL go to OUT.
REQ-010 Empty mid-block (a stall) SHALL hold the pop count with rd_en low, and SHALL resume without loss.
REQ-011 In OUT, blk_valid=1, and blk_data and blk_src SHALL stay stable until blk_valid&&blk_ready. On that handshake: go to IDLE, record the last-granted source, clear blk_valid.
REQ-012 Throughput SHALL be one block per 11 cycles with no stalls: 1 IDLE + 8 FILL + 1 LAST + 1 OUT, with blk_ready=1.
REQ-013 fifoN_rd_en SHALL never be asserted while fifoN_empty=1, and SHALL never be asserted in IDLE, LAST or OUT.

Reset
REQ-014 While rst_n=0, the state SHALL be IDLE and the following outputs SHALL be 0: fifo0_rd_en, fifo1_rd_en, blk_valid, busy, blk_data, blk_src. Last-granted SHALL be 1, so source 0 wins first.
REQ-015 Reset mid-block SHALL discard the partial block. Bytes already popped are lost, and this loss is accepted.

Configuration
REQ-016 With CIPHER_SCHED_STATS_EN defined, the block SHALL add outputs blk_cnt0[15:0] and blk_cnt1[15:0]:
- Each increments on every accepted block from its source.
- Each wraps 0xFFFF->0.
- Both reset to 0.
REQ-017 Without CIPHER_SCHED_STATS_EN, those ports and counters SHALL be absent and behaviour SHALL be otherwise identical.

Structure
REQ-018 Package cipher_sched_pkg SHALL hold the FSM state enum, BYTES_PER_BLOCK, the src_id_t typedef and the pop-counter width constant.
REQ-019 The 8-byte packing register with its byte index SHALL be the sub-module byte_packer. The arbiter and FSM SHALL stay in cipher_sched.

Verification
REQ-020 Single block: FIFO0 holds 0x01..0x08, FIFO1 empty, blk_ready=1 -> fifo0_rd_en high for exactly 8 consecutive cycles, then blk_data=0x0807060504030201, blk_src=0, blk_valid for 1 cycle.
REQ-021 Round-robin: both FIFOs hold 24 bytes, blk_ready=1 -> blk_src sequence 0,1,0,1,0,1 and blocks 11 cycles apart.
REQ-022 Stall: FIFO0 goes empty after 3 pops for 5 cycles -> rd_en low for those 5 cycles, and the block still equals bytes 0..7 in order.
REQ-023 Backpressure: blk_ready=0 for 20 cycles in OUT -> blk_valid and blk_data held constant, no pops on either FIFO, and acceptance on the first blk_ready=1.
REQ-024 Reset: rst_n pulsed low after 5 pops -> outputs go to 0 immediately, and the next block holds fresh bytes from source 0.
REQ-025 Stats (macro defined): 3 blocks from src0 and 2 from src1 -> blk_cnt0=3, blk_cnt1=2. With the counter preloaded to 0xFFFF, one more block -> 0.
